// File: rtl/multiport_ram_pkg.sv
// Shared types and helpers for the LVT-based multiport RAM.
// Holds the init FSM encoding and the priority encoder used for arbitration and forwarding.
package multiport_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Upper bound on write ports the priority encoder handles.
    localparam int MAX_PORTS = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lowest_set_index(input logic [MAX_PORTS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// Simple dual-port 1R1W bank with registered read data and no reset.
// A read of the address being written in the same cycle returns the old contents.
module sdp_ram_bank #(
    parameter int P_DEPTH = 16,
    parameter int P_WIDTH = 32,
    localparam int LP_AW  = $clog2(P_DEPTH)
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [LP_AW-1:0]   wr_addr_i,
    input  logic [P_WIDTH-1:0] wr_data_i,
    input  logic [LP_AW-1:0]   rd_addr_i,
    output logic [P_WIDTH-1:0] rd_data_o
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multiport RAM built from 1R1W banks; a live value table tracks the last writer per address.
// Includes write-first forwarding and a post-reset zero sweep before ready_o rises.
module lvt_multiport_ram
    import multiport_ram_pkg::*;
#(
    parameter int P_MEM_DEPTH     = 16,
    parameter int P_MEM_WIDTH     = 32,
    parameter int P_NUM_RD        = 4,
    parameter int P_NUM_WR        = 2,
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH),
    localparam int LP_LVT_WIDTH   = clog2_min1(P_NUM_WR)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    output logic                                     ready_o,
    input  logic [P_NUM_RD-1:0][LP_INDEX_WIDTH-1:0]  rd_addr_i,
    output logic [P_NUM_RD-1:0][P_MEM_WIDTH-1:0]     rd_data_o,
    input  logic [P_NUM_WR-1:0][LP_INDEX_WIDTH-1:0]  wr_addr_i,
    input  logic [P_NUM_WR-1:0][P_MEM_WIDTH-1:0]     wr_data_i,
    input  logic [P_NUM_WR-1:0]                      wr_valid_i,
    // Debug view of the init FSM.
    output state_e                                   state_o
);

    state_e                      state_q;
    state_e                      state_d;
    logic [LP_INDEX_WIDTH-1:0]   sweep_q;
    logic                        init_active;
    logic                        sweep_last;

    assign init_active = (state_q == INIT);
    assign sweep_last  = (sweep_q == LP_INDEX_WIDTH'(P_MEM_DEPTH - 1));
    assign ready_o     = (state_q == READY);
    assign state_o     = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (sweep_last) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_q <= '0;
        end else if (init_active) begin
            sweep_q <= sweep_q + 1'b1;
        end
    end

    // A write commits only if no lower-index valid port targets the same address.
    logic [P_NUM_WR-1:0]  wr_win;
    logic [MAX_PORTS-1:0] same_addr;

    always_comb begin
        wr_win    = '0;
        same_addr = '0;
        for (int w = 0; w < P_NUM_WR; w++) begin
            same_addr = '0;
            for (int j = 0; j < P_NUM_WR; j++) begin
                same_addr[j] = wr_valid_i[j] && (wr_addr_i[j] == wr_addr_i[w]);
            end
            wr_win[w] = wr_valid_i[w] && !init_active && (lowest_set_index(same_addr) == w);
        end
    end

    logic [P_MEM_WIDTH-1:0] bank_rdata [P_NUM_WR][P_NUM_RD];

    for (genvar w = 0; w < P_NUM_WR; w++) begin : g_wr
        logic                      bank_we;
        logic [LP_INDEX_WIDTH-1:0] bank_waddr;
        logic [P_MEM_WIDTH-1:0]    bank_wdata;

        assign bank_we    = !rst_i && (init_active || wr_win[w]);
        assign bank_waddr = init_active ? sweep_q : wr_addr_i[w];
        assign bank_wdata = init_active ? '0 : wr_data_i[w];

        for (genvar r = 0; r < P_NUM_RD; r++) begin : g_rd
            sdp_ram_bank #(
                .P_DEPTH (P_MEM_DEPTH),
                .P_WIDTH (P_MEM_WIDTH)
            ) u_bank (
                .clk_i     (clk_i),
                .wr_en_i   (bank_we),
                .wr_addr_i (bank_waddr),
                .wr_data_i (bank_wdata),
                .rd_addr_i (rd_addr_i[r]),
                .rd_data_o (bank_rdata[w][r])
            );
        end
    end

    logic [LP_LVT_WIDTH-1:0] lvt_q [P_MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (init_active) begin
                lvt_q[sweep_q] <= '0;
            end else begin
                for (int w = 0; w < P_NUM_WR; w++) begin
                    if (wr_win[w]) begin
                        lvt_q[wr_addr_i[w]] <= LP_LVT_WIDTH'(w);
                    end
                end
            end
        end
    end

    // Forwarding candidates for each read port, lowest write port first.
    logic [MAX_PORTS-1:0]                     rd_match;
    logic [P_NUM_RD-1:0]                      fwd_hit_d;
    logic [P_NUM_RD-1:0][P_MEM_WIDTH-1:0]     fwd_data_d;

    always_comb begin
        rd_match   = '0;
        fwd_hit_d  = '0;
        fwd_data_d = '0;
        for (int r = 0; r < P_NUM_RD; r++) begin
            rd_match = '0;
            for (int w = 0; w < P_NUM_WR; w++) begin
                rd_match[w] = wr_valid_i[w] && !init_active && (wr_addr_i[w] == rd_addr_i[r]);
            end
            fwd_hit_d[r]  = |rd_match;
            fwd_data_d[r] = wr_data_i[LP_LVT_WIDTH'(lowest_set_index(rd_match))];
        end
    end

    // LVT select and forward data are registered alongside the bank read.
    logic [P_NUM_RD-1:0][LP_LVT_WIDTH-1:0]    lvt_sel_q;
    logic [P_NUM_RD-1:0]                      fwd_hit_q;
    logic [P_NUM_RD-1:0][P_MEM_WIDTH-1:0]     fwd_data_q;
    logic                                     blank_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blank_q    <= 1'b1;
            fwd_hit_q  <= '0;
            fwd_data_q <= '0;
            lvt_sel_q  <= '0;
        end else begin
            blank_q    <= init_active;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            for (int r = 0; r < P_NUM_RD; r++) begin
                lvt_sel_q[r] <= lvt_q[rd_addr_i[r]];
            end
        end
    end

    // blank_q masks bank outputs that are unswept or were read during reset/init.
    always_comb begin
        rd_data_o = '0;
        if (!blank_q) begin
            for (int r = 0; r < P_NUM_RD; r++) begin
                rd_data_o[r] = fwd_hit_q[r] ? fwd_data_q[r] : bank_rdata[lvt_sel_q[r]][r];
            end
        end
    end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Bench for lvt_multiport_ram: directed scenarios then a randomised run,
// all checked each cycle against an array-based model with lowest-port-wins writes.
module tb_lvt_multiport_ram;
    import multiport_ram_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 4;

    logic                            clk = 1'b0;
    logic                            rst_i;
    logic                            ready_o;
    logic [NRD-1:0][AW-1:0]          rd_addr_i;
    logic [NRD-1:0][WIDTH-1:0]       rd_data_o;
    logic [NWR-1:0][AW-1:0]          wr_addr_i;
    logic [NWR-1:0][WIDTH-1:0]       wr_data_i;
    logic [NWR-1:0]                  wr_valid_i;
    state_e                          state_o;

    lvt_multiport_ram #(
        .P_MEM_DEPTH (DEPTH),
        .P_MEM_WIDTH (WIDTH),
        .P_NUM_RD    (NRD),
        .P_NUM_WR    (NWR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .ready_o    (ready_o),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .wr_valid_i (wr_valid_i),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents, ready flag and sweep progress.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_ready = 1'b0;
    int               m_sweep = 0;
    logic [WIDTH-1:0] exp_rd [NRD];

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        state_e es;
        for (int r = 0; r < NRD; r++) begin
            exp_rd[r] = '0;
            if (!rst_i && m_ready) begin
                exp_rd[r] = m_mem[rd_addr_i[r]];
                for (int w = NWR - 1; w >= 0; w--) begin
                    if (wr_valid_i[w] && wr_addr_i[w] == rd_addr_i[r]) exp_rd[r] = wr_data_i[w];
                end
            end
        end
        @(posedge clk);
        if (rst_i) begin
            m_ready = 1'b0;
            m_sweep = 0;
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == DEPTH) m_ready = 1'b1;
        end else begin
            for (int w = NWR - 1; w >= 0; w--) begin
                if (wr_valid_i[w]) m_mem[wr_addr_i[w]] = wr_data_i[w];
            end
        end
        #1;
        for (int r = 0; r < NRD; r++) chk($sformatf("model_rd[%0d]", r), rd_data_o[r], exp_rd[r]);
        es = m_ready ? READY : INIT;
        chk("model_ready", 32'(ready_o), 32'(m_ready));
        chk("model_state", 32'(state_o), 32'(es));
    endtask

    task automatic idle();
        wr_valid_i = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [WIDTH-1:0] d);
        wr_valid_i[p] = 1'b1;
        wr_addr_i[p]  = AW'(a);
        wr_data_i[p]  = d;
    endtask

    task automatic rd_all(input int a);
        for (int r = 0; r < NRD; r++) rd_addr_i[r] = AW'(a);
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] want);
        for (int r = 0; r < NRD; r++) chk($sformatf("%s[%0d]", tag, r), rd_data_o[r], want);
    endtask

    initial begin
        rst_i      = 1'b1;
        rd_addr_i  = '0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        wr_valid_i = '0;

        // Init: 3 reset cycles, then a 16-edge sweep with a dropped write.
        repeat (3) tick();
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk_all("reset_rd", '0);
        rst_i = 1'b0;
        rd_all(3);
        wr(0, 3, 32'hDEAD);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            idle();
            chk("init_ready", 32'(ready_o), 32'(i == DEPTH - 1));
            chk_all("init_rd", '0);
            rd_all((i + 1) % DEPTH);
        end
        rd_all(3);
        tick();
        chk_all("dead_dropped", '0);
        for (int a = 0; a < DEPTH; a += NRD) begin
            for (int r = 0; r < NRD; r++) rd_addr_i[r] = AW'(a + r);
            tick();
            chk_all("post_init_zero", '0);
        end

        // Basic writes on both ports.
        wr(0, 5, 32'h11111111);
        tick();
        idle();
        wr(1, 9, 32'h22222222);
        tick();
        idle();
        rd_addr_i = {AW'(9), AW'(5), AW'(9), AW'(5)};
        tick();
        chk("basic_p0", rd_data_o[0], 32'h11111111);
        chk("basic_p1", rd_data_o[1], 32'h22222222);
        chk("basic_p2", rd_data_o[2], 32'h11111111);
        chk("basic_p3", rd_data_o[3], 32'h22222222);
        rd_addr_i = {AW'(5), AW'(9), AW'(5), AW'(9)};
        tick();
        chk("basic_swap_p0", rd_data_o[0], 32'h22222222);
        chk("basic_swap_p3", rd_data_o[3], 32'h11111111);

        // LVT override across ports.
        wr(0, 7, 32'hA);
        tick();
        idle();
        wr(1, 7, 32'hB);
        tick();
        idle();
        rd_all(7);
        tick();
        chk_all("lvt_b", 32'hB);
        wr(0, 7, 32'hC);
        tick();
        idle();
        tick();
        chk_all("lvt_c", 32'hC);

        // Same-address collision: port 0 wins, both forwarded and stored.
        rd_all(2);
        wr(0, 2, 32'h100);
        wr(1, 2, 32'h200);
        tick();
        idle();
        chk_all("coll_fwd", 32'h100);
        tick();
        chk_all("coll_stored", 32'h100);

        // Forwarding, then an invalid write to the same address.
        rd_all(4);
        wr(1, 4, 32'h55);
        tick();
        idle();
        chk_all("fwd_hit", 32'h55);
        wr(1, 4, 32'h66);
        wr_valid_i[1] = 1'b0;
        tick();
        chk_all("fwd_invalid", 32'h55);

        // Mid-operation reset discards filled contents.
        for (int a = 0; a < DEPTH; a++) begin
            wr(0, a, 32'h1000 + 32'(a));
            tick();
        end
        idle();
        rd_all(5);
        tick();
        chk_all("filled", 32'h1005);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk_all("midrst_rd", '0);
        repeat (DEPTH) tick();
        chk("midrst_ready_back", 32'(ready_o), 32'd1);
        for (int a = 0; a < DEPTH; a += NRD) begin
            for (int r = 0; r < NRD; r++) rd_addr_i[r] = AW'(a + r);
            tick();
            chk_all("midrst_zero", '0);
        end

        // Randomised traffic with narrow address ranges to provoke collisions.
        for (int n = 0; n < 10000; n++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 1) ? 3 : DEPTH - 1;
            rst_i = ($urandom_range(0, 999) == 0);
            for (int w = 0; w < NWR; w++) begin
                wr_valid_i[w] = 1'($urandom_range(0, 1));
                wr_addr_i[w]  = AW'($urandom_range(0, hi));
                wr_data_i[w]  = $urandom;
            end
            for (int r = 0; r < NRD; r++) rd_addr_i[r] = AW'($urandom_range(0, hi));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
